// File: rtl/valid_ready_fifo_pkg.sv
// Shared defaults for the valid/ready family (master, slave, fifo) and the
// width helper used for occupancy counters and pointers.
package valid_ready_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/valid_ready_fifo_mem.sv
// DEPTH x DATA_W register array with one synchronous write port and an
// asynchronous read port; contents clear on reset.
module valid_ready_fifo_mem
    import valid_ready_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] storage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (wr_en) begin
            storage[wr_addr] <= wr_data;
        end
    end

    assign rd_data = storage[rd_addr];

endmodule

// File: rtl/valid_ready_fifo.sv
// Valid/ready elastic buffer: DEPTH-entry first-word-fall-through FIFO with
// input stall, synchronous flush, occupancy count and almost-full flag.
module valid_ready_fifo
    import valid_ready_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         i_s_data,
    input  logic                      i_s_valid,
    output logic                      o_s_ready,
    input  logic                      i_s_stall,
    output logic [DATA_W-1:0]         o_m_data,
    output logic                      o_m_valid,
    input  logic                      i_m_ready,
    input  logic                      i_flush,
    output logic [cnt_w(DEPTH)-1:0]   o_count,
    output logic                      o_almost_full
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              push;
    logic              pop;

    // Ready is deliberately independent of i_m_ready: a full FIFO refuses
    // input even in a cycle where the head word is being taken.
    assign full      = (count == CNT_W'(DEPTH));
    assign o_s_ready = rst_n && !full && !i_s_stall && !i_flush;
    assign o_m_valid = (count != '0);
    assign push      = i_s_valid && o_s_ready;
    assign pop       = o_m_valid && i_m_ready && !i_flush;

    assign o_count       = count;
    assign o_almost_full = (count >= CNT_W'(AF_LEVEL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    valid_ready_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (i_s_data),
        .rd_addr (rd_ptr),
        .rd_data (o_m_data)
    );

endmodule

// File: tb/tb_valid_ready_fifo.sv
// Bench for valid_ready_fifo: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the buffer.
module tb_valid_ready_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int AF     = DEPTH - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] i_s_data;
    logic              i_s_valid;
    logic              o_s_ready;
    logic              i_s_stall;
    logic [DATA_W-1:0] o_m_data;
    logic              o_m_valid;
    logic              i_m_ready;
    logic              i_flush;
    logic [2:0]        o_count;
    logic              o_almost_full;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] model_q [$];

    always #5 clk = ~clk;

    valid_ready_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_s_data      (i_s_data),
        .i_s_valid     (i_s_valid),
        .o_s_ready     (o_s_ready),
        .i_s_stall     (i_s_stall),
        .o_m_data      (o_m_data),
        .o_m_valid     (o_m_valid),
        .i_m_ready     (i_m_ready),
        .i_flush       (i_flush),
        .o_count       (o_count),
        .o_almost_full (o_almost_full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs to the model mid-cycle, then advance
    // the model by the transfers the handshake rules say happen at the edge.
    task automatic tick();
        logic exp_ready;
        logic do_push;
        logic do_pop;
        @(negedge clk);
        exp_ready = rst_n && (model_q.size() < DEPTH) && !i_s_stall && !i_flush;
        check("s_ready", 32'(o_s_ready), 32'(exp_ready));
        check("m_valid", 32'(o_m_valid), 32'(model_q.size() != 0));
        check("count", 32'(o_count), 32'(model_q.size()));
        check("almost_full", 32'(o_almost_full), 32'(model_q.size() >= AF));
        if (model_q.size() != 0) begin
            check("m_data", 32'(o_m_data), 32'(model_q[0]));
        end
        do_push = i_s_valid && exp_ready;
        do_pop  = (model_q.size() != 0) && i_m_ready && !i_flush;
        @(posedge clk);
        #1;
        if (!rst_n || i_flush) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(i_s_data);
        end
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic mr,
                         input logic st, input logic fl);
        i_s_valid = v;
        i_s_data  = d;
        i_m_ready = mr;
        i_s_stall = st;
        i_flush   = fl;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset held for three cycles, then idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(o_s_ready), 32'd0);
        check("rst_valid", 32'(o_m_valid), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_data", 32'(o_m_data), 32'd0);
        check("rst_af", 32'(o_almost_full), 32'd0);
        rst_n = 1'b1;
        #1;
        check("release_ready", 32'(o_s_ready), 32'd1);
        repeat (2) tick();

        // Fill to full with the consumer stalled, then drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i * 8'h11), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        check("full_count", 32'(o_count), 32'd4);
        check("full_head", 32'(o_m_data), 32'h11);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        check("drained", 32'(o_count), 32'd0);

        // Streaming, pointers wrap several times
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();

        // Full with a simultaneous pop: pop happens, push refused this cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        tick();
        check("full_pop_count", 32'(o_count), 32'd3);
        tick();
        check("refill_count", 32'(o_count), 32'd3);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();

        // Stall while draining
        drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        repeat (6) tick();
        check("stall_drained", 32'(o_count), 32'd0);

        // Flush at count 3 with a push attempt in the flush cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
        tick();
        check("flush_count", 32'(o_count), 32'd0);
        check("flush_valid", 32'(o_m_valid), 32'd0);
        drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();

        // Asynchronous reset mid-stream at count 2
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(o_m_valid), 32'd0);
        check("async_count", 32'(o_count), 32'd0);
        check("async_data", 32'(o_m_data), 32'd0);
        check("async_ready", 32'(o_s_ready), 32'd0);
        model_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 31) == 0));
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (6) tick();
        check("final_count", 32'(o_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
